// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared types and defaults for the RAM port arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

   localparam int c_ADDR_W = 5;
   localparam int c_DATA_W = 3;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_READ      = 2'd2,
      ST_READ_WAIT = 2'd3
   } arb_state_t;

   // Which requester was granted most recently; used for alternation on conflict
   typedef enum logic {
      GRANT_READ  = 1'b0,
      GRANT_WRITE = 1'b1
   } grant_t;

endpackage
`default_nettype wire

// File: rtl/scan_addr_counter.sv
`default_nettype none
// ============================================================================
// Module   : scan_addr_counter
// Purpose  : Scan address counter with increment and synchronous clear.
//            Clear wins over increment; wraps by natural overflow.
// Revision : 1.0 - initial release
// ============================================================================
module scan_addr_counter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              inc,
   output logic [ADDR_W-1:0] count
);

   logic [ADDR_W-1:0] r_count;

   // Count register: clear has priority so a disabled scanner restarts at 0
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + ADDR_W'(1);
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares one single-port synchronous RAM between a 4-phase
//            handshake writer and a tick-paced scan reader. Owns the scan
//            address, the arbitration and the tagged read-result registers.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W,
   parameter int DATA_W = c_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              scan_en,
   input  logic              tick,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              overrun
);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   grant_t            r_last_grant;
   logic              r_scan_pend;
   logic              r_wr_armed;
   logic              r_overrun;
   logic              r_rd_valid;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [DATA_W-1:0] r_rd_data;
   logic [ADDR_W-1:0] w_scan_addr;
   logic              w_wr_elig;
   logic              w_read_busy;

   assign w_wr_elig   = wr_req & r_wr_armed;
   assign w_read_busy = (r_state == ST_READ) || (r_state == ST_READ_WAIT);

   scan_addr_counter #(
      .ADDR_W (ADDR_W)
   ) u_scan_addr_counter (
      .clock (clock),
      .reset (reset),
      .clr   (~scan_en),
      .inc   (r_state == ST_READ_WAIT),
      .count (w_scan_addr)
   );

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state arbitration and RAM port drive (outputs decode from state so
   // reset drops ram_wren without waiting for a clock)
   always_comb begin
      w_next_state = r_state;
      ram_addr     = w_scan_addr;
      ram_din      = '0;
      ram_wren     = 1'b0;
      wr_ack       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_wr_elig && r_scan_pend) begin
               w_next_state = (r_last_grant == GRANT_READ) ? ST_WRITE : ST_READ;
            end else if (w_wr_elig) begin
               w_next_state = ST_WRITE;
            end else if (r_scan_pend) begin
               w_next_state = ST_READ;
            end
         end
         ST_WRITE: begin
            ram_addr     = wr_addr;
            ram_din      = wr_data;
            ram_wren     = 1'b1;
            wr_ack       = 1'b1;
            w_next_state = r_scan_pend ? ST_READ : ST_IDLE;
         end
         ST_READ: begin
            w_next_state = ST_READ_WAIT;
         end
         ST_READ_WAIT: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Request bookkeeping: pending scan, writer re-arm, grant history, overrun
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_scan_pend  <= 1'b0;
         r_wr_armed   <= 1'b0;
         r_last_grant <= GRANT_READ;
         r_overrun    <= 1'b0;
      end else begin
         if (!scan_en) begin
            r_scan_pend <= 1'b0;
         end else if (w_next_state == ST_READ && r_state != ST_READ) begin
            r_scan_pend <= 1'b0;
         end else if (tick && !r_scan_pend && !w_read_busy) begin
            r_scan_pend <= 1'b1;
         end

         if (!scan_en) begin
            r_overrun <= 1'b0;
         end else if (tick && (r_scan_pend || w_read_busy)) begin
            r_overrun <= 1'b1;
         end

         // Writer must show wr_req low before it can be granted again
         if (w_next_state == ST_WRITE && r_state != ST_WRITE) begin
            r_wr_armed <= 1'b0;
         end else if (!wr_req) begin
            r_wr_armed <= 1'b1;
         end

         if (w_next_state == ST_WRITE && r_state != ST_WRITE) begin
            r_last_grant <= GRANT_WRITE;
         end else if (w_next_state == ST_READ && r_state != ST_READ) begin
            r_last_grant <= GRANT_READ;
         end
      end
   end

   // Read-result capture: RAM data is valid during READ_WAIT
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rd_valid <= 1'b0;
         r_rd_addr  <= '0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= (r_state == ST_READ_WAIT);
         if (r_state == ST_READ_WAIT) begin
            r_rd_addr <= w_scan_addr;
            r_rd_data <= ram_dout;
         end
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_addr  = r_rd_addr;
   assign rd_data  = r_rd_data;
   assign busy     = (r_state != ST_IDLE);
   assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench for ram_port_arbiter with a behavioural
//            32x3 synchronous RAM and a read-result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       scan_en = 1'b1;
   logic       tick = 1'b0;
   logic       wr_req = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [2:0] wr_data = '0;
   logic       wr_ack;
   logic [4:0] ram_addr;
   logic [2:0] ram_din;
   logic       ram_wren;
   logic [2:0] ram_dout;
   logic       rd_valid;
   logic [4:0] rd_addr;
   logic [2:0] rd_data;
   logic       busy;
   logic       overrun;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q [$];
   logic [2:0] mem [32] = '{default: 3'd6};

   always #5 clock = ~clock;

   ram_port_arbiter #(.ADDR_W(5), .DATA_W(3)) dut (
      .clock    (clock),
      .reset    (reset),
      .scan_en  (scan_en),
      .tick     (tick),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ack   (wr_ack),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_wren (ram_wren),
      .ram_dout (ram_dout),
      .rd_valid (rd_valid),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy),
      .overrun  (overrun)
   );

   // Behavioural single-port RAM, read-first, one-cycle read latency
   always @(posedge clock) begin
      if (ram_wren) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   // Scoreboard monitor: every rd_valid must match the oldest expected entry
   always @(negedge clock) begin
      if (reset && rd_valid) begin
         logic [7:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected: got addr=%0d data=%0d, none expected", rd_addr, rd_data);
         end else begin
            e = exp_q.pop_front();
            if ({rd_addr, rd_data} !== e[7:0]) begin
               failures++;
               $display("FAIL rd_result: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                        rd_addr, rd_data, e[7:3], e[2:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic push_exp(input logic [4:0] a, input logic [2:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic do_write(input logic [4:0] a, input logic [2:0] d);
      bit got;
      got = 1'b0;
      wr_addr = a;
      wr_data = d;
      wr_req  = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         cyc(1);
         if (wr_ack) got = 1'b1;
      end
      wr_req = 1'b0;
      chk("wr_ack_seen", 32'(got), 32'd1);
      cyc(1);
   endtask

   task automatic send_tick();
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
   endtask

   initial begin
      int acks;
      int wrens;

      // Reset state
      #2;
      chk("rst_wr_ack", 32'(wr_ack), 0);
      chk("rst_ram_wren", 32'(ram_wren), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_din", 32'(ram_din), 0);
      chk("rst_outputs", {rd_valid, rd_addr, rd_data, busy, overrun}, 0);
      cyc(2);
      reset = 1'b1;
      cyc(3);
      chk("idle_outputs", {wr_ack, ram_wren, rd_valid, busy, overrun}, 0);

      // Single scan read latency: rd_valid in the cycle after E3
      push_exp(5'd0, 3'd6);
      send_tick();                         // E0 just passed
      chk("lat_e0_valid", 32'(rd_valid), 0);
      cyc(1);
      chk("lat_e1_valid", 32'(rd_valid), 0);
      chk("lat_e1_busy", 32'(busy), 1);
      cyc(1);
      chk("lat_e2_valid", 32'(rd_valid), 0);
      cyc(1);
      chk("lat_e3_valid", 32'(rd_valid), 1);
      cyc(3);

      // Fill RAM through the write port
      for (int i = 0; i < 32; i++) do_write(5'(i), 3'(i % 8));
      for (int i = 0; i < 32; i += 7) chk("mem_fill", 32'(mem[i]), 32'(i % 8));

      // Restart scanner at 0, then 33 spaced ticks including the wrap
      scan_en = 1'b0;
      cyc(1);
      scan_en = 1'b1;
      cyc(1);
      chk("scan_restart_addr", 32'(ram_addr), 0);
      for (int i = 0; i < 33; i++) begin
         push_exp(5'(i % 32), 3'((i % 32) % 8));
         send_tick();
         cyc(6);
      end
      chk("scan_overrun_clear", 32'(overrun), 0);

      // Writer holds wr_req high: exactly one grant
      acks  = 0;
      wrens = 0;
      wr_addr = 5'd5;
      wr_data = 3'd3;
      wr_req  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cyc(1);
         if (wr_ack) acks++;
         if (ram_wren) wrens++;
      end
      wr_req = 1'b0;
      chk("hold_ack_count", 32'(acks), 1);
      chk("hold_wren_count", 32'(wrens), 1);
      chk("hold_mem5", 32'(mem[5]), 3);
      cyc(2);

      // Fresh reset, then tick and write together: WRITE, READ, READ_WAIT
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      cyc(2);
      push_exp(5'd0, 3'd0);
      wr_addr = 5'd9;
      wr_data = 3'd2;
      wr_req  = 1'b1;
      tick    = 1'b1;
      cyc(1);                              // E0
      tick = 1'b0;
      chk("both_e0_wren", 32'(ram_wren), 1);
      chk("both_e0_ack", 32'(wr_ack), 1);
      chk("both_e0_addr", 32'(ram_addr), 9);
      wr_req = 1'b0;
      cyc(1);                              // E1: READ
      chk("both_e1_wren", 32'(ram_wren), 0);
      chk("both_e1_addr", 32'(ram_addr), 0);
      chk("both_e1_busy", 32'(busy), 1);
      cyc(1);                              // E2: READ_WAIT
      chk("both_e2_wren", 32'(ram_wren), 0);
      chk("both_e2_valid", 32'(rd_valid), 0);
      cyc(1);                              // E3
      chk("both_e3_valid", 32'(rd_valid), 1);
      chk("both_mem9", 32'(mem[9]), 2);
      cyc(3);

      // Back-to-back ticks: one read, overrun set; scan_en low clears it
      push_exp(5'd1, 3'd1);
      send_tick();
      send_tick();
      chk("ovr_set", 32'(overrun), 1);
      cyc(6);
      chk("ovr_sticky", 32'(overrun), 1);
      scan_en = 1'b0;
      cyc(1);
      chk("ovr_cleared", 32'(overrun), 0);
      chk("ovr_scan_addr0", 32'(ram_addr), 0);
      scan_en = 1'b1;
      cyc(1);
      push_exp(5'd0, 3'd0);
      send_tick();
      cyc(6);

      // Reset during WRITE: port drops asynchronously, write is lost
      wr_addr = 5'd12;
      wr_data = 3'd1;
      wr_req  = 1'b1;
      cyc(1);
      chk("rstw_wren_before", 32'(ram_wren), 1);
      chk("rstw_addr_before", 32'(ram_addr), 12);
      #2;
      reset = 1'b0;
      #1;
      chk("rstw_wren", 32'(ram_wren), 0);
      chk("rstw_ack", 32'(wr_ack), 0);
      chk("rstw_busy", 32'(busy), 0);
      chk("rstw_scan_addr", 32'(ram_addr), 0);
      wr_req = 1'b0;
      cyc(2);
      chk("rstw_mem12", 32'(mem[12]), 4);
      reset = 1'b1;
      cyc(3);

      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
